// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg
//   Shared definitions for the sequential ALU: opcode encodings, the
//   IDLE/BUSY/DONE state encoding and a helper that decides whether an
//   accepted operation needs the iterative multiply/divide datapath.
package seq_alu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_NOR  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Divide by zero is answered in one cycle, so only a real division iterates.
  function automatic logic is_iterative(input logic [3:0] op, input logic b_is_zero);
    return (op == OP_MUL) || ((op == OP_DIVU) && !b_is_zero);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv_core.sv
// seq_alu_muldiv_core
//   Iterative datapath for unsigned shift-add multiply and restoring divide.
//   One iteration per clock while step is high; finish flags the last one.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load operands and arm the iteration counter
//   step              perform one iteration this clock
//   is_div_in         1 = restoring divide, 0 = shift-add multiply (sampled on start)
//   a, b              operands (multiplier/multiplicand or dividend/divisor)
//   res_lo, res_hi    value the registers take after the current iteration
//                     (product low/high or quotient/remainder on the last one)
//   finish            the current step is the final iteration
module seq_alu_muldiv_core #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div_in,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             finish
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mq;
  logic [WIDTH-1:0] opd;
  logic             div_mode;
  logic [CNT_W-1:0] count;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_mq;

  // acc holds the product high half / partial remainder, mq the multiplier
  // being consumed (LSB first) or the dividend being replaced by quotient
  // bits. For division acc < divisor always holds, so bit WIDTH of the
  // trial difference is a reliable borrow flag.
  always_comb begin
    mul_sum   = {1'b0, acc} + {1'b0, opd};
    div_shift = {acc, mq[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opd};
    nxt_acc   = acc;
    nxt_mq    = mq;
    if (div_mode) begin
      if (!div_diff[WIDTH]) begin
        nxt_acc = div_diff[WIDTH-1:0];
        nxt_mq  = {mq[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = div_shift[WIDTH-1:0];
        nxt_mq  = {mq[WIDTH-2:0], 1'b0};
      end
    end else if (mq[0]) begin
      nxt_acc = mul_sum[WIDTH:1];
      nxt_mq  = {mul_sum[0], mq[WIDTH-1:1]};
    end else begin
      nxt_acc = {1'b0, acc[WIDTH-1:1]};
      nxt_mq  = {acc[0], mq[WIDTH-1:1]};
    end
  end

  assign res_lo = nxt_mq;
  assign res_hi = nxt_acc;
  assign finish = step && (count == CNT_W'(1));

  // Operand/accumulator registers and the iteration counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      mq       <= '0;
      opd      <= '0;
      div_mode <= 1'b0;
      count    <= '0;
    end else if (start) begin
      acc      <= '0;
      mq       <= a;
      opd      <= b;
      div_mode <= is_div_in;
      count    <= CNT_W'(WIDTH);
    end else if (step) begin
      acc      <= nxt_acc;
      mq       <= nxt_mq;
      count    <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu
//   Multi-cycle ALU with valid/ready handshakes. Simple ops finish in one
//   clock; MUL and DIVU iterate in seq_alu_muldiv_core for WIDTH+1 clocks.
//   Build option: define SEQ_ALU_OVERFLOW_EN to generate signed ADD/SUB
//   overflow detection; otherwise the overflow port is tied to 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (accept = in_valid & in_ready)
//   op, a, b              opcode and operands
//   out_valid / out_ready result handshake
//   result_lo, result_hi  result / MUL product halves / DIVU quotient,remainder
//   zero, div_zero, overflow  status flags, meaningful while out_valid
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             div_zero,
  output logic             overflow
);

  logic [1:0]       state;
  logic             accept;
  logic             start_iter;
  logic             core_finish;
  logic [WIDTH-1:0] core_lo;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] sc_lo;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_dz;

  // A finished result may be swapped for a new operation in the same clock
  // the consumer takes it, giving back-to-back issue.
  assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign out_valid  = (state == ST_DONE);
  assign accept     = in_valid && in_ready;
  assign start_iter = accept && is_iterative(op, b == '0);

  // Single-cycle results. DIVU only lands here when b is zero.
  always_comb begin
    sum   = a + b;
    diff  = a - b;
    sc_lo = '0;
    sc_hi = '0;
    sc_dz = 1'b0;
    case (op)
      OP_ADD:  sc_lo = sum;
      OP_SUB:  sc_lo = diff;
      OP_AND:  sc_lo = a & b;
      OP_OR:   sc_lo = a | b;
      OP_SLT:  sc_lo = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLTU: sc_lo = {{(WIDTH-1){1'b0}}, a < b};
      OP_XOR:  sc_lo = a ^ b;
      OP_NOR:  sc_lo = ~(a | b);
      OP_DIVU: begin
        sc_lo = '1;
        sc_hi = a;
        sc_dz = 1'b1;
      end
      default: ;
    endcase
  end

  seq_alu_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_iter),
    .step      (state == ST_BUSY),
    .is_div_in (op == OP_DIVU),
    .a         (a),
    .b         (b),
    .res_lo    (core_lo),
    .res_hi    (core_hi),
    .finish    (core_finish)
  );

  // Control FSM and result registers. Results are written either on the
  // accept edge (single-cycle ops) or on the last iteration edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      result_lo <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      if (start_iter) begin
        state <= ST_BUSY;
      end else begin
        state     <= ST_DONE;
        result_lo <= sc_lo;
        result_hi <= sc_hi;
        zero      <= (sc_lo == '0);
        div_zero  <= sc_dz;
      end
    end else if ((state == ST_BUSY) && core_finish) begin
      state     <= ST_DONE;
      result_lo <= core_lo;
      result_hi <= core_hi;
      zero      <= (core_lo == '0);
      div_zero  <= 1'b0;
    end else if ((state == ST_DONE) && out_ready) begin
      state <= ST_IDLE;
    end
  end

`ifdef SEQ_ALU_OVERFLOW_EN
  logic ovf_next;

  // Two's-complement overflow: operands that look alike in sign (after
  // negating b for SUB) producing a result of the other sign.
  always_comb begin
    ovf_next = 1'b0;
    if (op == OP_ADD)
      ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    else if (op == OP_SUB)
      ovf_next = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow <= 1'b0;
    else if (accept && !start_iter)
      overflow <= ovf_next;
    else if ((state == ST_BUSY) && core_finish)
      overflow <= 1'b0;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu
//   Scoreboard bench for seq_alu (WIDTH=32). Expected results come from a
//   behavioural model, are queued when an operation is issued and popped
//   when out_valid appears. Honours SEQ_ALU_OVERFLOW_EN in the model.
module tb_seq_alu;

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        zero;
    logic        dz;
    logic        ov;
    logic [7:0]  lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        zero;
  logic        div_zero;
  logic        overflow;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_alu #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result_lo (result_lo),
    .result_hi (result_hi),
    .zero      (zero),
    .div_zero  (div_zero),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Reference model, written from the opcode table independently of the RTL.
  function automatic exp_t model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    logic [63:0] p;
    longint      s;
    e     = '0;
    e.lat = 8'd1;
    s     = 0;
    case (o)
      4'd1:  e.lo = x + y;
      4'd2:  e.lo = x - y;
      4'd3:  e.lo = x & y;
      4'd4:  e.lo = x | y;
      4'd5:  e.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'd6:  e.lo = (x < y) ? 32'd1 : 32'd0;
      4'd7:  e.lo = x ^ y;
      4'd8:  e.lo = ~(x | y);
      4'd9: begin
        p     = {32'd0, x} * {32'd0, y};
        e.lo  = p[31:0];
        e.hi  = p[63:32];
        e.lat = 8'd33;
      end
      4'd10: begin
        if (y == 0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
          e.dz = 1'b1;
        end else begin
          e.lo  = x / y;
          e.hi  = x % y;
          e.lat = 8'd33;
        end
      end
      default: e.lo = '0;
    endcase
    e.zero = (e.lo == 0);
`ifdef SEQ_ALU_OVERFLOW_EN
    if (o == 4'd1) s = longint'($signed(x)) + longint'($signed(y));
    if (o == 4'd2) s = longint'($signed(x)) - longint'($signed(y));
    e.ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
`endif
    return e;
  endfunction

  // Called at a negedge: presents one operation, queues its expectation,
  // reports in_ready just before the accepting edge, then drops in_valid.
  task automatic apply_stimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic rdy);
    in_valid = 1'b1;
    op = o;
    a  = x;
    b  = y;
    sb.push_back(model(o, x, y));
    #1 rdy = in_ready;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts accept-to-out_valid edges, bounded so a stuck DUT cannot hang.
  task automatic wait_result(output int cycles);
    cycles = 1;
    while (!out_valid && cycles < 200) begin
      @(posedge clk);
      #1 cycles++;
    end
  endtask

  task automatic release_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, result_lo, result_hi, zero, div_zero, overflow} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_state: got rdy=%b vld=%b lo=%h hi=%h z=%b dz=%b ov=%b, expected rdy=1 vld=0 all else 0",
               in_ready, out_valid, result_lo, result_hi, zero, div_zero, overflow);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_single_cycle();
    logic [3:0]  ops[12] = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd4, 4'd7, 4'd8, 4'd0, 4'd12, 4'd10, 4'd1};
    logic [31:0] as[12]  = '{32'd5, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hF0F0_1234, 32'h0F00_0001,
                            32'hAAAA_5555, 32'h1234_0000, 32'd44, 32'd99, 32'd9, 32'h7FFF_FFFF};
    logic [31:0] bs[12]  = '{32'd7, 32'd7, 32'd1, 32'd1, 32'h0FF0_FFFF, 32'h00F0_0010,
                            32'hFFFF_0000, 32'h0000_5678, 32'd3, 32'd1, 32'd0, 32'd1};
    logic rdy;
    int   cyc;
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      apply_stimulus(ops[i], as[i], bs[i], rdy);
      wait_result(cyc);
      e = sb.pop_front();
      checks++;
      if (!rdy || cyc != int'(e.lat)) begin
        errors++;
        $display("[TB] FAIL op%0d_latency: got rdy=%b latency=%0d, expected rdy=1 latency=%0d", ops[i], rdy, cyc, e.lat);
      end
      checks++;
      if ({result_lo, result_hi, zero, div_zero, overflow} !== {e.lo, e.hi, e.zero, e.dz, e.ov}) begin
        errors++;
        $display("[TB] FAIL op%0d_result: got lo=%h hi=%h z=%b dz=%b ov=%b, expected lo=%h hi=%h z=%b dz=%b ov=%b",
                 ops[i], result_lo, result_hi, zero, div_zero, overflow, e.lo, e.hi, e.zero, e.dz, e.ov);
      end
      release_result();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL drain_idle: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_muldiv();
    logic [3:0]  ops[6] = '{4'd9, 4'd10, 4'd9, 4'd10, 4'd9, 4'd10};
    logic [31:0] as[6];
    logic [31:0] bs[6];
    logic rdy;
    logic busy_rdy;
    int   cyc;
    exp_t e;
    as[0] = 32'hFFFF_FFFF; bs[0] = 32'd2;
    as[1] = 32'd100;       bs[1] = 32'd7;
    as[2] = $urandom;      bs[2] = $urandom;
    as[3] = $urandom;      bs[3] = $urandom_range(1, 5000);
    as[4] = 32'hFFFF_FFFF; bs[4] = 32'hFFFF_FFFF;
    as[5] = 32'd5;         bs[5] = 32'hFFFF_FFFF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      apply_stimulus(ops[i], as[i], bs[i], rdy);
      busy_rdy = in_ready;
      wait_result(cyc);
      e = sb.pop_front();
      checks++;
      if (!rdy || busy_rdy || cyc != int'(e.lat)) begin
        errors++;
        $display("[TB] FAIL op%0d_iter_timing: got rdy=%b busy_rdy=%b latency=%0d, expected rdy=1 busy_rdy=0 latency=%0d",
                 ops[i], rdy, busy_rdy, cyc, e.lat);
      end
      checks++;
      if ({result_lo, result_hi, zero, div_zero, overflow} !== {e.lo, e.hi, e.zero, e.dz, e.ov}) begin
        errors++;
        $display("[TB] FAIL op%0d_iter_result a=%h b=%h: got lo=%h hi=%h z=%b dz=%b ov=%b, expected lo=%h hi=%h z=%b dz=%b ov=%b",
                 ops[i], as[i], bs[i], result_lo, result_hi, zero, div_zero, overflow, e.lo, e.hi, e.zero, e.dz, e.ov);
      end
      release_result();
    end
  endtask

  task automatic test_back_to_back();
    logic rdy;
    int   cyc;
    int   held;
    exp_t e;
    @(negedge clk);
    apply_stimulus(4'd1, 32'd3, 32'd4, rdy);
    wait_result(cyc);
    e = sb.pop_front();
    held = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 if (out_valid === 1'b1 && result_lo === e.lo && in_ready === 1'b0) held++;
    end
    checks++;
    if (held != 5) begin
      errors++;
      $display("[TB] FAIL backpressure_hold: got %0d stable cycles (lo=%h), expected 5 (lo=%h)", held, result_lo, e.lo);
    end
    @(negedge clk);
    out_ready = 1'b1;
    apply_stimulus(4'd1, 32'd10, 32'd20, rdy);
    out_ready = 1'b0;
    e = sb.pop_front();
    checks++;
    if (!rdy || out_valid !== 1'b1 || result_lo !== e.lo || zero !== e.zero) begin
      errors++;
      $display("[TB] FAIL back_to_back: got rdy=%b vld=%b lo=%h z=%b, expected rdy=1 vld=1 lo=%h z=%b",
               rdy, out_valid, result_lo, zero, e.lo, e.zero);
    end
    release_result();
  endtask

  task automatic test_reset_busy();
    logic rdy;
    int   seen;
    @(negedge clk);
    apply_stimulus(4'd9, 32'hFFFF_FFFF, 32'd3, rdy);
    void'(sb.pop_back());
    repeat (9) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL busy_cycle10: got rdy=%b vld=%b, expected rdy=0 vld=0", in_ready, out_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, result_lo, result_hi, zero, div_zero, overflow} !== {1'b1, 1'b0, 64'd0, 3'b000}) begin
      errors++;
      $display("[TB] FAIL reset_mid_busy: got rdy=%b vld=%b lo=%h hi=%h z=%b dz=%b ov=%b, expected rdy=1 vld=0 all else 0",
               in_ready, out_valid, result_lo, result_hi, zero, div_zero, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("[TB] FAIL no_partial_result: got %0d cycles with vld/rdy disturbed, expected 0", seen);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_muldiv();
    test_back_to_back();
    test_reset_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
